// File: rtl/riscv_lsu_pkg.sv
// ============================================================================
// Module   : riscv_lsu_pkg
// Brief    : Shared size codes, FSM state type and lane helpers for riscv_lsu.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package riscv_lsu_pkg;

    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    function automatic logic is_byte(input logic [2:0] size);
        return (size == LDST_B) || (size == LDST_BU);
    endfunction

    function automatic logic is_half(input logic [2:0] size);
        return (size == LDST_H) || (size == LDST_HU);
    endfunction

    // Every code that is neither a byte nor a half access behaves as a word.
    function automatic logic misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
        if (is_byte(size)) begin
            return 1'b0;
        end else if (is_half(size)) begin
            return addr_lo[0];
        end
        return addr_lo != 2'b00;
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] addr_lo);
        if (is_byte(size)) begin
            return 4'b0001 << addr_lo;
        end else if (is_half(size)) begin
            return 4'b0011 << {addr_lo[1], 1'b0};
        end
        return 4'b1111;
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] size, input logic [31:0] wd);
        if (is_byte(size)) begin
            return {4{wd[7:0]}};
        end else if (is_half(size)) begin
            return {2{wd[15:0]}};
        end
        return wd;
    endfunction

endpackage

`default_nettype wire

// File: rtl/riscv_lsu_load_extend.sv
// ============================================================================
// Module   : lsu_load_extend
// Brief    : Selects the addressed lane of a memory word and sign/zero extends it.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module lsu_load_extend
    import riscv_lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  size_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo_i)
            2'd0:    byte_sel = word_i[7:0];
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            default: byte_sel = word_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];

        case (size_i)
            LDST_B:  data_o = {{24{byte_sel[7]}}, byte_sel};
            LDST_BU: data_o = {24'd0, byte_sel};
            LDST_H:  data_o = {{16{half_sel[15]}}, half_sel};
            LDST_HU: data_o = {16'd0, half_sel};
            default: data_o = word_i;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/riscv_lsu.sv
// ============================================================================
// Module   : riscv_lsu
// Brief    : Core-to-memory load/store unit; optional watchdog via LSU_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module riscv_lsu
    import riscv_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        misalign_o,
    output logic        timeout_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    lsu_state_t  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  size_q, size_d;
    logic        we_q, we_d;
    logic [31:0] wd_q, wd_d;
    logic [31:0] word_q, word_d;

    logic        req_ok;
    logic        req_misal;
    logic        timeout_hit;
    logic [31:0] ext_data;

    // The combinational request path must be silent while reset is held.
    assign req_ok    = core_req_i & rst_ni;
    assign req_misal = misaligned(core_size_i, core_addr_i[1:0]);

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 32) ? 32 : CNT_RAW);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (state_q == WAIT) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_hit = (state_q == WAIT) && (cnt_q == CNT_W'(TIMEOUT_CYCLES));
`else
    logic [31:0] timeout_cfg_unused;
    assign timeout_cfg_unused = TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
`endif

    lsu_load_extend u_load_extend (
        .word_i    (word_q),
        .addr_lo_i (addr_q[1:0]),
        .size_i    (size_q),
        .data_o    (ext_data)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        size_d       = size_q;
        we_d         = we_q;
        wd_d         = wd_q;
        word_d       = word_q;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        mem_be_o     = 4'b0000;
        mem_addr_o   = 32'd0;
        mem_wd_o     = 32'd0;
        misalign_o   = 1'b0;
        timeout_o    = 1'b0;
        core_stall_o = 1'b0;
        core_rd_o    = 32'd0;

        case (state_q)
            IDLE: begin
                if (req_ok) begin
                    core_stall_o = 1'b1;
                    addr_d       = core_addr_i;
                    size_d       = core_size_i;
                    we_d         = core_we_i;
                    wd_d         = store_data(core_size_i, core_wd_i);
                    if (req_misal) begin
                        misalign_o = 1'b1;
                        word_d     = 32'd0;
                        state_d    = DONE;
                    end else begin
                        mem_req_o  = 1'b1;
                        mem_we_o   = core_we_i;
                        mem_be_o   = byte_en(core_size_i, core_addr_i[1:0]);
                        mem_addr_o = {core_addr_i[31:2], 2'b00};
                        mem_wd_o   = store_data(core_size_i, core_wd_i);
                        if (mem_ready_i) begin
                            word_d  = mem_rd_i;
                            state_d = DONE;
                        end else begin
                            state_d = WAIT;
                        end
                    end
                end
            end
            WAIT: begin
                core_stall_o = 1'b1;
                // A ready strobe in the expiry cycle still completes normally.
                if (timeout_hit && !mem_ready_i) begin
                    timeout_o = 1'b1;
                    word_d    = 32'd0;
                    state_d   = DONE;
                end else begin
                    mem_req_o  = 1'b1;
                    mem_we_o   = we_q;
                    mem_be_o   = byte_en(size_q, addr_q[1:0]);
                    mem_addr_o = {addr_q[31:2], 2'b00};
                    mem_wd_o   = wd_q;
                    if (mem_ready_i) begin
                        word_d  = mem_rd_i;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                core_rd_o = ext_data;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            addr_q  <= 32'd0;
            size_q  <= 3'd0;
            we_q    <= 1'b0;
            wd_q    <= 32'd0;
            word_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            we_q    <= we_d;
            wd_q    <= wd_d;
            word_q  <= word_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_riscv_lsu.sv
// ============================================================================
// Module   : tb_riscv_lsu
// Brief    : Scoreboard-based self-checking bench for riscv_lsu.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_riscv_lsu;
    import riscv_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        core_req = 1'b0;
    logic        core_we = 1'b0;
    logic [2:0]  core_size = 3'd0;
    logic [31:0] core_addr = 32'd0;
    logic [31:0] core_wd = 32'd0;
    logic [31:0] core_rd;
    logic        core_stall;
    logic        misalign;
    logic        timeout;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd = 32'd0;
    logic        mem_ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    riscv_lsu #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .core_req_i   (core_req),
        .core_we_i    (core_we),
        .core_size_i  (core_size),
        .core_addr_i  (core_addr),
        .core_wd_i    (core_wd),
        .core_rd_o    (core_rd),
        .core_stall_o (core_stall),
        .misalign_o   (misalign),
        .timeout_o    (timeout),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .mem_be_o     (mem_be),
        .mem_addr_o   (mem_addr),
        .mem_wd_o     (mem_wd),
        .mem_rd_i     (mem_rd),
        .mem_ready_i  (mem_ready)
    );

    // Memory model + observer: issues one request starting at the next clock,
    // strobes ready in stall cycle rdy_at (never if negative), returns at DONE.
    task automatic run_access(
        input  logic        we,
        input  logic [2:0]  size,
        input  logic [31:0] addr,
        input  logic [31:0] wd,
        input  logic [31:0] memword,
        input  int          rdy_at,
        output int          stalls,
        output int          reqs,
        output int          reqs_done,
        output int          misal,
        output int          tmo,
        output logic        first_req,
        output logic [3:0]  be,
        output logic [31:0] maddr,
        output logic [31:0] mwd,
        output logic        mwe,
        output logic [31:0] rd,
        output logic        done
    );
        stalls = 0; reqs = 0; reqs_done = 0; misal = 0; tmo = 0;
        be = 4'd0; maddr = 32'd0; mwd = 32'd0; mwe = 1'b0; rd = 32'd0; done = 1'b0;
        @(posedge clk); #1;
        core_req = 1'b1; core_we = we; core_size = size; core_addr = addr; core_wd = wd;
        mem_rd = memword; mem_ready = 1'b0;
        #1;
        first_req = mem_req;
        for (int k = 0; k < 64; k++) begin
            mem_ready = mem_req && (k == rdy_at);
            @(negedge clk);
            if (core_stall) begin
                stalls++;
                if (mem_req) begin
                    reqs++;
                    be = mem_be; maddr = mem_addr; mwd = mem_wd; mwe = mem_we;
                end
                misal += int'(misalign);
                tmo   += int'(timeout);
            end else begin
                reqs_done += int'(mem_req);
                rd = core_rd;
                done = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
    endtask

    task automatic release_core();
        @(posedge clk); #1;
        core_req = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        core_req = 1'b1; core_size = LDST_W; core_addr = 32'h0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        n_checks++; if (core_stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b want 0", core_stall); end
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
        n_checks++; if (mem_be !== 4'b0000) begin n_fail++; $display("FAIL rst_mem_be: got %b want 0000", mem_be); end
        n_checks++; if (core_rd !== 32'd0) begin n_fail++; $display("FAIL rst_core_rd: got %h want 0", core_rd); end
        n_checks++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL rst_misalign: got %b want 0", misalign); end
        n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL rst_timeout: got %b want 0", timeout); end
        core_req = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_lb();
        int st, rq, rqd, ms, tm; logic fr, mwe, dn; logic [3:0] be; logic [31:0] ma, mwd, rd, exp;
        exp_q.push_back(32'hFFFF_FF80);
        run_access(1'b0, LDST_B, 32'h0000_0103, 32'h0, 32'h80FF_7F01, 1,
                   st, rq, rqd, ms, tm, fr, be, ma, mwd, mwe, rd, dn);
        n_checks++; if (dn !== 1'b1) begin n_fail++; $display("FAIL lb_done: got %b want 1", dn); end
        n_checks++; if (be !== 4'b1000) begin n_fail++; $display("FAIL lb_be: got %b want 1000", be); end
        n_checks++; if (ma !== 32'h100) begin n_fail++; $display("FAIL lb_addr: got %h want 00000100", ma); end
        n_checks++; if (st != 2) begin n_fail++; $display("FAIL lb_stall: got %0d want 2", st); end
        n_checks++; if (mwe !== 1'b0) begin n_fail++; $display("FAIL lb_we: got %b want 0", mwe); end
        exp = exp_q.pop_front();
        n_checks++; if (rd !== exp) begin n_fail++; $display("FAIL lb_rd: got %h want %h", rd, exp); end
        release_core();
    endtask

    task automatic test_sh();
        int st, rq, rqd, ms, tm; logic fr, mwe, dn; logic [3:0] be; logic [31:0] ma, mwd, rd;
        run_access(1'b1, LDST_H, 32'h0000_0202, 32'h1234_ABCD, 32'h0, 0,
                   st, rq, rqd, ms, tm, fr, be, ma, mwd, mwe, rd, dn);
        n_checks++; if (dn !== 1'b1) begin n_fail++; $display("FAIL sh_done: got %b want 1", dn); end
        n_checks++; if (be !== 4'b1100) begin n_fail++; $display("FAIL sh_be: got %b want 1100", be); end
        n_checks++; if (mwd !== 32'hABCD_ABCD) begin n_fail++; $display("FAIL sh_wd: got %h want abcdabcd", mwd); end
        n_checks++; if (mwe !== 1'b1) begin n_fail++; $display("FAIL sh_we: got %b want 1", mwe); end
        n_checks++; if (ma !== 32'h200) begin n_fail++; $display("FAIL sh_addr: got %h want 00000200", ma); end
        n_checks++; if (st != 1) begin n_fail++; $display("FAIL sh_stall: got %0d want 1", st); end
        release_core();
    endtask

    task automatic test_store_byte();
        int st, rq, rqd, ms, tm; logic fr, mwe, dn; logic [3:0] be; logic [31:0] ma, mwd, rd;
        run_access(1'b1, LDST_B, 32'h0000_0301, 32'hAABB_CC5A, 32'h0, 2,
                   st, rq, rqd, ms, tm, fr, be, ma, mwd, mwe, rd, dn);
        n_checks++; if (be !== 4'b0010) begin n_fail++; $display("FAIL sb_be: got %b want 0010", be); end
        n_checks++; if (mwd !== 32'h5A5A_5A5A) begin n_fail++; $display("FAIL sb_wd: got %h want 5a5a5a5a", mwd); end
        n_checks++; if (rq != 3) begin n_fail++; $display("FAIL sb_req_held: got %0d want 3", rq); end
        release_core();
    endtask

    task automatic test_load_extend();
        logic [2:0]  sz [6] = '{LDST_BU, LDST_H, LDST_B, LDST_B, LDST_HU, LDST_W};
        logic [31:0] ad [6] = '{32'h102, 32'h102, 32'h101, 32'h100, 32'h102, 32'h100};
        logic [31:0] ev [6] = '{32'h0000_00FF, 32'hFFFF_80FF, 32'h0000_007F,
                                32'h0000_0001, 32'h0000_80FF, 32'h80FF_7F01};
        logic [3:0]  eb [6] = '{4'b0100, 4'b1100, 4'b0010, 4'b0001, 4'b1100, 4'b1111};
        for (int i = 0; i < 6; i++) begin
            int st, rq, rqd, ms, tm; logic fr, mwe, dn; logic [3:0] be; logic [31:0] ma, mwd, rd, exp;
            exp_q.push_back(ev[i]);
            run_access(1'b0, sz[i], ad[i], 32'h0, 32'h80FF_7F01, i % 3,
                       st, rq, rqd, ms, tm, fr, be, ma, mwd, mwe, rd, dn);
            n_checks++; if (be !== eb[i]) begin n_fail++; $display("FAIL ext_be[%0d]: got %b want %b", i, be, eb[i]); end
            n_checks++; if (st != (i % 3) + 1) begin n_fail++; $display("FAIL ext_stall[%0d]: got %0d want %0d", i, st, (i % 3) + 1); end
            exp = exp_q.pop_front();
            n_checks++; if (rd !== exp) begin n_fail++; $display("FAIL ext_rd[%0d]: got %h want %h", i, rd, exp); end
            release_core();
        end
    endtask

    task automatic test_back_to_back();
        int st, rq, rqd, ms, tm; logic fr, mwe, dn; logic [3:0] be; logic [31:0] ma, mwd, rd, exp;
        exp_q.push_back(32'h0000_F00F);
        exp_q.push_back(32'h1234_5678);
        run_access(1'b0, LDST_HU, 32'h0, 32'h0, 32'h0000_F00F, 1,
                   st, rq, rqd, ms, tm, fr, be, ma, mwd, mwe, rd, dn);
        exp = exp_q.pop_front();
        n_checks++; if (rd !== exp) begin n_fail++; $display("FAIL b2b_lhu_rd: got %h want %h", rd, exp); end
        n_checks++; if (rqd != 0) begin n_fail++; $display("FAIL b2b_lhu_done_req: got %0d want 0", rqd); end
        run_access(1'b0, LDST_W, 32'h4, 32'h0, 32'h1234_5678, 1,
                   st, rq, rqd, ms, tm, fr, be, ma, mwd, mwe, rd, dn);
        n_checks++; if (fr !== 1'b1) begin n_fail++; $display("FAIL b2b_lw_first_req: got %b want 1", fr); end
        n_checks++; if (ma !== 32'h4) begin n_fail++; $display("FAIL b2b_lw_addr: got %h want 00000004", ma); end
        n_checks++; if (rqd != 0) begin n_fail++; $display("FAIL b2b_lw_done_req: got %0d want 0", rqd); end
        exp = exp_q.pop_front();
        n_checks++; if (rd !== exp) begin n_fail++; $display("FAIL b2b_lw_rd: got %h want %h", rd, exp); end
        release_core();
    endtask

    task automatic test_misalign();
        logic [2:0]  sz [3] = '{LDST_W, LDST_H, 3'd3};
        logic [31:0] ad [3] = '{32'h0000_0006, 32'h0000_0101, 32'h0000_0002};
        for (int i = 0; i < 3; i++) begin
            int st, rq, rqd, ms, tm; logic fr, mwe, dn; logic [3:0] be; logic [31:0] ma, mwd, rd, exp;
            exp_q.push_back(32'd0);
            run_access(1'b0, sz[i], ad[i], 32'h0, 32'hFFFF_FFFF, 0,
                       st, rq, rqd, ms, tm, fr, be, ma, mwd, mwe, rd, dn);
            n_checks++; if (rq + rqd != 0) begin n_fail++; $display("FAIL mis_req[%0d]: got %0d want 0", i, rq + rqd); end
            n_checks++; if (ms != 1) begin n_fail++; $display("FAIL mis_pulse[%0d]: got %0d want 1", i, ms); end
            n_checks++; if (st != 1) begin n_fail++; $display("FAIL mis_stall[%0d]: got %0d want 1", i, st); end
            exp = exp_q.pop_front();
            n_checks++; if (rd !== exp) begin n_fail++; $display("FAIL mis_rd[%0d]: got %h want %h", i, rd, exp); end
            release_core();
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] exp;
        @(posedge clk); #1;
        core_req = 1'b1; core_we = 1'b0; core_size = LDST_W; core_addr = 32'h10;
        mem_rd = 32'hCAFE_0001; mem_ready = 1'b0;
        @(posedge clk); #1;
        n_checks++; if ({core_stall, mem_req} !== 2'b11) begin n_fail++; $display("FAIL rm_wait: got %b want 11", {core_stall, mem_req}); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rm_req: got %b want 0", mem_req); end
        n_checks++; if (core_stall !== 1'b0) begin n_fail++; $display("FAIL rm_stall: got %b want 0", core_stall); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rm_fresh_req: got %b want 1", mem_req); end
        n_checks++; if (mem_addr !== 32'h10) begin n_fail++; $display("FAIL rm_fresh_addr: got %h want 00000010", mem_addr); end
        exp_q.push_back(32'hCAFE_0001);
        mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        exp = exp_q.pop_front();
        n_checks++; if (core_stall !== 1'b0) begin n_fail++; $display("FAIL rm_done_stall: got %b want 0", core_stall); end
        n_checks++; if (core_rd !== exp) begin n_fail++; $display("FAIL rm_rd: got %h want %h", core_rd, exp); end
        release_core();
    endtask

`ifdef LSU_TIMEOUT_EN
    task automatic test_timeout();
        int st, rq, rqd, ms, tm; logic fr, mwe, dn; logic [3:0] be; logic [31:0] ma, mwd, rd, exp;
        exp_q.push_back(32'd0);
        run_access(1'b0, LDST_W, 32'h40, 32'h0, 32'h5555_AAAA, -1,
                   st, rq, rqd, ms, tm, fr, be, ma, mwd, mwe, rd, dn);
        n_checks++; if (dn !== 1'b1) begin n_fail++; $display("FAIL tmo_done: got %b want 1", dn); end
        n_checks++; if (tm != 1) begin n_fail++; $display("FAIL tmo_pulse: got %0d want 1", tm); end
        n_checks++; if (rq != 5) begin n_fail++; $display("FAIL tmo_req_cycles: got %0d want 5", rq); end
        n_checks++; if (st != 6) begin n_fail++; $display("FAIL tmo_stall: got %0d want 6", st); end
        exp = exp_q.pop_front();
        n_checks++; if (rd !== exp) begin n_fail++; $display("FAIL tmo_rd: got %h want %h", rd, exp); end
        release_core();
    endtask
`endif

    initial begin
        test_reset();
        test_lb();
        test_sh();
        test_store_byte();
        test_load_extend();
        test_back_to_back();
        test_misalign();
        test_reset_mid();
`ifdef LSU_TIMEOUT_EN
        test_timeout();
`endif
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d want 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
